// File: rtl/sr04_range_filter.sv
// sr04_range_filter
// Converts raw HC-SR04 echo tick counts into centimetres with a serial
// restoring divider, smooths them with a 4-sample moving average and
// derives a proximity flag with hysteresis.
//
// Handshake: sample_in is offered on every cycle sample_valid is high.
// An offer with nonzero data is accepted only while the block is idle
// (busy low). A nonzero offer while busy is dropped and counted. A zero
// sample is never an offer. dist_valid is a one-cycle strobe with no
// back-pressure; the consumer must take dist_cm on that cycle.
module sr04_range_filter #(
  parameter int TICKS_PER_CM = 928,
  parameter int NEAR_CM      = 20,
  parameter int HYST_CM      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sample_in,
  input  logic        sample_valid,
  output logic [15:0] dist_cm,
  output logic        dist_valid,
  output logic        near,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_AVG  = 2'd2
  } state_t;

  localparam logic [32:0] DIVISOR  = 33'(TICKS_PER_CM);
  localparam logic [15:0] NEAR_TH  = 16'(NEAR_CM);
  localparam logic [15:0] CLEAR_TH = 16'(NEAR_CM + HYST_CM);

  state_t      state;
  // acc holds the dividend at the start of division; quotient bits shift
  // in from the bottom as dividend bits shift out of the top.
  logic [31:0] acc;
  logic [31:0] rem;
  logic [4:0]  bit_cnt;
  // The three most recent quotients. Together with the quotient being
  // retired in AVG they form the 4-entry averaging window; the oldest
  // entry is only ever needed for the mean formed as it leaves.
  logic [15:0] hist [3];
  logic [2:0]  fill;

  logic        offer;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_next;
  logic [31:0] acc_next;
  logic [15:0] q_sat;
  logic [17:0] win_sum;
  logic [15:0] win_mean;

  assign offer     = sample_valid && (sample_in != 32'd0);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // One restoring-division step plus the window mean for the AVG edge.
  always_comb begin
    rem_shift = {rem, acc[31]};
    rem_ge    = (rem_shift >= DIVISOR);
    rem_next  = rem_ge ? 32'(rem_shift - DIVISOR) : rem_shift[31:0];
    acc_next  = {acc[30:0], rem_ge};
    q_sat     = (acc[31:16] != 16'd0) ? 16'hFFFF : acc[15:0];
    win_sum   = 18'(q_sat) + 18'(hist[0]) + 18'(hist[1]) + 18'(hist[2]);
    win_mean  = win_sum[17:2];
  end

  // Control FSM, divider datapath, averaging window and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      acc        <= 32'd0;
      rem        <= 32'd0;
      bit_cnt    <= 5'd0;
      hist[0]    <= 16'd0;
      hist[1]    <= 16'd0;
      hist[2]    <= 16'd0;
      fill       <= 3'd0;
      dist_cm    <= 16'd0;
      dist_valid <= 1'b0;
      near       <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      dist_valid <= 1'b0;

      if (offer && (state != S_IDLE) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (offer) begin
            acc     <= sample_in;
            rem     <= 32'd0;
            bit_cnt <= 5'd0;
            state   <= S_DIV;
          end
        end
        S_DIV: begin
          acc     <= acc_next;
          rem     <= rem_next;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            state <= S_AVG;
          end
        end
        S_AVG: begin
          hist[0] <= q_sat;
          hist[1] <= hist[0];
          hist[2] <= hist[1];
          if (fill != 3'd4) begin
            fill <= fill + 3'd1;
          end
          // Window is full once this quotient lands (three already held).
          if (fill >= 3'd3) begin
            dist_cm    <= win_mean;
            dist_valid <= 1'b1;
            if (win_mean < NEAR_TH) begin
              near <= 1'b1;
            end else if (win_mean >= CLEAR_TH) begin
              near <= 1'b0;
            end
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr04_range_filter.sv
// Bench for sr04_range_filter: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the filter.
module tb_sr04_range_filter;

  localparam int TPC  = 928;
  localparam int NEAR = 20;
  localparam int HYST = 5;
  localparam int LAT  = 34;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] sample_in = 32'd0;
  logic        sample_valid = 1'b0;
  logic [15:0] dist_cm;
  logic        dist_valid;
  logic        near;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  sr04_range_filter #(
    .TICKS_PER_CM(TPC),
    .NEAR_CM(NEAR),
    .HYST_CM(HYST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .dist_cm(dist_cm),
    .dist_valid(dist_valid),
    .near(near),
    .busy(busy),
    .drop_cnt(drop_cnt),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural reference model ----------------
  // A sample occupies the block for 33 edges after its accepting edge;
  // on the last of those its centimetre value joins the window.
  int          m_busy_left = 0;
  logic [15:0] m_pending = 16'd0;
  logic [7:0]  m_drop = 8'd0;
  logic [15:0] m_dist = 16'd0;
  logic        m_valid = 1'b0;
  logic        m_near = 1'b0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] to_cm(input logic [31:0] s);
    longint q;
    q = longint'(s) / TPC;
    return (q > 65535) ? 16'hFFFF : 16'(q);
  endfunction

  always @(posedge clk) begin
    m_valid = 1'b0;
    if (reset) begin
      m_busy_left = 0;
      m_drop = 8'd0;
      m_dist = 16'd0;
      m_near = 1'b0;
      exp_q.delete();
    end else if (m_busy_left > 0) begin
      if (sample_valid && sample_in != 0 && m_drop != 8'd255) m_drop = m_drop + 8'd1;
      m_busy_left = m_busy_left - 1;
      if (m_busy_left == 0) begin
        int sum;
        exp_q.push_back(m_pending);
        if (exp_q.size() > 4) void'(exp_q.pop_front());
        if (exp_q.size() == 4) begin
          sum = 0;
          foreach (exp_q[i]) sum += int'(exp_q[i]);
          m_dist = 16'(sum / 4);
          m_valid = 1'b1;
          if (int'(m_dist) < NEAR) m_near = 1'b1;
          else if (int'(m_dist) >= NEAR + HYST) m_near = 1'b0;
        end
      end
    end else if (sample_valid && sample_in != 0) begin
      m_pending = to_cm(sample_in);
      m_busy_left = LAT - 1;
    end
  end

  // Edge counter and dist_valid pulse monitor.
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dist_valid === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Offer one sample once idle, then watch up to 40 edges for a pulse.
  task automatic run_sample(input logic [31:0] s, output bit seen, output int lat,
                            output logic [15:0] d, output logic n);
    int acc_cyc;
    wait_idle();
    sample_valid = 1'b1;
    sample_in = s;
    @(negedge clk);
    acc_cyc = cyc;
    sample_valid = 1'b0;
    sample_in = $urandom;
    seen = 1'b0;
    lat = 0;
    d = 16'd0;
    n = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (dist_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        lat = cyc - acc_cyc + 1;
        d = dist_cm;
        n = near;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sample_valid = 1'b1;
    sample_in = 32'd5000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (dist_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", dist_valid); end
    n_cmp++; if (near !== 1'b0) begin n_bad++; $display("FAIL reset_near: got %b want 0", near); end
    n_cmp++; if (dist_cm !== 16'd0) begin n_bad++; $display("FAIL reset_dist: got %0d want 0", dist_cm); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic test_basic();
    bit seen; int lat; logic [15:0] d; logic n;
    do_reset();
    for (int i = 0; i < 3; i++) run_sample(32'd9280, seen, lat, d, n);
    n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL basic_fill_pulses: got %0d want 0", pulse_cnt); end
    run_sample(32'd9280, seen, lat, d, n);
    n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", pulse_cnt); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (d !== 16'd10) begin n_bad++; $display("FAIL basic_dist: got %0d want 10", d); end
    n_cmp++; if (n !== 1'b1) begin n_bad++; $display("FAIL basic_near: got %b want 1", n); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL basic_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    bit seen; int lat; logic [15:0] d; logic n; int k;
    // Window already full; offer exactly in the dist_valid cycle.
    sample_valid = 1'b1;
    sample_in = 32'd18560;
    @(negedge clk);
    sample_valid = 1'b0;
    k = 0;
    while (dist_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    n_cmp++; if (dist_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_pulse: got %b want 1", dist_valid); end
    sample_valid = 1'b1;
    sample_in = 32'd27840;
    @(negedge clk);
    sample_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: busy=%b want 1", busy); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt); end
    run_sample(32'd9280, seen, lat, d, n);
    wait_idle();
    // Window now 10,20,30,10 -> 17.
    n_cmp++; if (dist_cm !== 16'd17) begin n_bad++; $display("FAIL b2b_dist: got %0d want 17", dist_cm); end
    n_cmp++; if (dist_cm !== m_dist) begin n_bad++; $display("FAIL b2b_model: got %0d want %0d", dist_cm, m_dist); end
  endtask

  task automatic test_range();
    bit seen; int lat; logic [15:0] d; logic n;
    do_reset();
    for (int i = 0; i < 4; i++) run_sample(32'd278400, seen, lat, d, n);
    n_cmp++; if (d !== 16'd300) begin n_bad++; $display("FAIL range_300: got %0d want 300", d); end
    n_cmp++; if (n !== 1'b0) begin n_bad++; $display("FAIL range_near: got %b want 0", n); end
    run_sample(32'd278399, seen, lat, d, n);
    n_cmp++; if (d !== 16'd299) begin n_bad++; $display("FAIL range_299: got %0d want 299", d); end
  endtask

  task automatic test_saturate();
    bit seen; int lat; logic [15:0] d; logic n;
    do_reset();
    for (int i = 0; i < 4; i++) run_sample(32'hFFFFFFFF, seen, lat, d, n);
    n_cmp++; if (d !== 16'hFFFF) begin n_bad++; $display("FAIL sat_dist: got %h want ffff", d); end
    run_sample(32'd9280, seen, lat, d, n);
    // (3*65535 + 10) / 4 = 49153
    n_cmp++; if (d !== 16'd49153) begin n_bad++; $display("FAIL sat_mix: got %0d want 49153", d); end
  endtask

  task automatic test_hysteresis();
    bit seen; int lat; logic [15:0] d; logic n;
    int exp_d[8] = '{13, 16, 19, 22, 23, 24, 25, 26};
    bit exp_n[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) run_sample(32'd9280, seen, lat, d, n);
    n_cmp++; if (n !== 1'b1) begin n_bad++; $display("FAIL hyst_start_near: got %b want 1", n); end
    for (int i = 0; i < 8; i++) begin
      run_sample((i < 4) ? 32'd20416 : 32'd24128, seen, lat, d, n);
      n_cmp++; if (d !== 16'(exp_d[i])) begin n_bad++; $display("FAIL hyst_dist[%0d]: got %0d want %0d", i, d, exp_d[i]); end
      n_cmp++; if (n !== exp_n[i]) begin n_bad++; $display("FAIL hyst_near[%0d]: got %b want %b", i, n, exp_n[i]); end
    end
  endtask

  task automatic test_drops();
    do_reset();
    sample_valid = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      sample_in = $urandom_range(32'd1000, 32'd200000);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd33) begin n_bad++; $display("FAIL drop_33: got %0d want 33", drop_cnt); end
    n_cmp++; if (drop_cnt !== m_drop) begin n_bad++; $display("FAIL drop_model: got %0d want %0d", drop_cnt, m_drop); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_single_accept: busy=%b want 0", busy); end
    sample_valid = 1'b1;
    for (int i = 0; i < 320; i++) begin
      sample_in = $urandom_range(32'd1, 32'hFFFFFFFF);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bit seen; int lat; logic [15:0] d; logic n;
    do_reset();
    sample_valid = 1'b1;
    sample_in = 32'd9280;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_cnt = 0;
    repeat (40) @(negedge clk);
    n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL mid_reset_pulse: got %0d want 0", pulse_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      run_sample(32'd46400, seen, lat, d, n);
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_reset_fill[%0d]: pulse seen=%b want 0", i, seen); end
    end
    run_sample(32'd46400, seen, lat, d, n);
    n_cmp++; if (seen !== 1'b1 || lat !== LAT) begin n_bad++; $display("FAIL mid_reset_fourth: seen=%b lat=%0d want 1/%0d", seen, lat, LAT); end
    n_cmp++; if (d !== 16'd50) begin n_bad++; $display("FAIL mid_reset_dist: got %0d want 50", d); end
  endtask

  task automatic test_random();
    int bad_here;
    do_reset();
    bad_here = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      sample_valid = (r < 35);
      if (r < 5) sample_in = 32'd0;
      else if (r < 25) sample_in = $urandom_range(32'd500, 32'd40000);
      else if (r < 32) sample_in = $urandom_range(32'd1, 32'd2000000);
      else sample_in = $urandom;
      @(negedge clk);
      n_cmp++;
      if (dist_valid !== m_valid || dist_cm !== m_dist || near !== m_near ||
          busy !== (m_busy_left > 0) || drop_cnt !== m_drop) begin
        n_bad++;
        bad_here++;
        if (bad_here < 10)
          $display("FAIL random[%0d]: got v=%b d=%0d n=%b b=%b drop=%0d want v=%b d=%0d n=%b b=%b drop=%0d",
                   i, dist_valid, dist_cm, near, busy, drop_cnt,
                   m_valid, m_dist, m_near, (m_busy_left > 0), m_drop);
      end
    end
    sample_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_range();
    test_saturate();
    test_hysteresis();
    test_drops();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
